// File: rtl/sram_like_mem_slave.sv
// rtl/sram_like_mem_slave.sv - SRAM-like bus responder with word memory and in-order response queue
// Optional: SRAM_LIKE_RAND_STALL_EN gates addr_ok with an LFSR to inject random address stalls.
module sram_like_mem_slave #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4,
   parameter int LAT    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);
   localparam int PW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH + 1);
   localparam int CW = $clog2(LAT + 1);

   logic [31:0]       mem_q [2**ADDR_W];
   logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
   logic [NW-1:0]     count_q, count_d;
   logic [DEPTH-1:0]  vld_q;
   logic [DEPTH-1:0]  is_wr_q;
   logic [31:0]       data_q [DEPTH];
   logic [CW-1:0]     cnt_q  [DEPTH];
   logic [1:0]        size_q [DEPTH];
   logic [ADDR_W-1:0] idx;
   logic              push, pop;
   logic              unused_ok;

   assign idx     = addr[ADDR_W+1:2];
   assign push    = req & addr_ok;
   assign pop     = data_ok;
   assign data_ok = vld_q[head_q] & (cnt_q[head_q] == '0);
   assign rdata   = is_wr_q[head_q] ? 32'h0 : data_q[head_q];

   // size is captured for visibility only; upper address bits alias by design
   assign unused_ok = ^{addr[31:ADDR_W+2], addr[1:0], size_q[head_q]};

`ifdef SRAM_LIKE_RAND_STALL_EN
   logic [15:0] lfsr_q;
   logic        lfsr_fb;
   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) lfsr_q <= 16'hACE1;
      else         lfsr_q <= {lfsr_q[14:0], lfsr_fb};
   end

   assign addr_ok = (count_q != NW'(DEPTH)) & lfsr_q[0];
`else
   assign addr_ok = (count_q != NW'(DEPTH));
`endif

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
         is_wr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            cnt_q[i]  <= '0;
            size_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
         end
         if (pop) vld_q[head_q] <= 1'b0;
         // tail slot is never valid while not full, so push cannot clash with the decrement above
         if (push) begin
            vld_q[tail_q]   <= 1'b1;
            is_wr_q[tail_q] <= wr;
            data_q[tail_q]  <= mem_q[idx];
            cnt_q[tail_q]   <= CW'(LAT - 1);
            size_q[tail_q]  <= size;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (resetn && push && wr) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// tb/tb_sram_like_mem_slave.sv - scoreboard bench for sram_like_mem_slave
module tb_sram_like_mem_slave;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 4;
   localparam int LAT    = 4;  // equal to DEPTH so back-to-back reads fill the queue

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req = 1'b0, wr = 1'b0;
   logic [1:0]  size = 2'd2;
   logic [3:0]  wstrb = 4'h0;
   logic [31:0] addr = '0, wdata = '0;
   logic        addr_ok, data_ok;
   logic [31:0] rdata;

   sram_like_mem_slave #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
      .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
      .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [int];
   int          n_vec = 0, n_err = 0;
   int          cyc = 0, last_exp = 0, n_dok = 0;
   logic [31:0] last_rdata = '0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!resetn) begin
         sb.delete();
         last_exp = 0;
      end else begin
         if (data_ok) begin
            if (sb.size() == 0) begin
               check_val("dok_unexp", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_val("rdata", rdata, e.data);
               check_val("lat_cyc", 32'(cyc), 32'(e.cyc));
               last_rdata = rdata;
               n_dok++;
            end
         end
         if (req && addr_ok) begin
            exp_t e;
            int   w;
            w = int'(addr[ADDR_W+1:2]);
            if (wr) begin
               logic [31:0] m;
               m = mdl.exists(w) ? mdl[w] : 32'h0;
               for (int i = 0; i < 4; i++) if (wstrb[i]) m[8*i +: 8] = wdata[8*i +: 8];
               mdl[w] = m;
               e.data = 32'h0;
            end else begin
               e.data = mdl.exists(w) ? mdl[w] : 32'hxxxxxxxx;
            end
            e.cyc = cyc + LAT;
            if (e.cyc <= last_exp) e.cyc = last_exp + 1;
            last_exp = e.cyc;
            sb.push_back(e);
         end
      end
   end

   task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int stalls);
      req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s; size = 2'd2;
      stalls = 0;
      @(negedge clk);
      while (!addr_ok && stalls < 50) begin
         stalls++;
         @(negedge clk);
      end
      if (!addr_ok) check_val("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      req = 1'b0; wr = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) check_val("drain_timeout", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, st_sum, dok0;
      logic [31:0] atab [4];
      atab = '{32'h10, 32'h4, 32'h20, 32'h1030};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_addr_ok", 32'(addr_ok), 32'd1);
      check_val("rst_data_ok", 32'(data_ok), 32'd0);
      check_val("rst_rdata", rdata, 32'h0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;

      do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, st);
      check_val("t1_wr_stall", 32'(st), 32'd0);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, st);
      check_val("t1_rd_stall", 32'(st), 32'd0);
      drain();
      check_val("t1_rd_data", last_rdata, 32'hDEADBEEF);

      do_req(1'b1, 32'h10, 32'h0000AB00, 4'b0010, st);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, st);
      drain();
      check_val("partial_wr", last_rdata, 32'hDEADABEF);

      do_req(1'b1, 32'h10, 32'h12345678, 4'h0, st);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, st);
      drain();
      check_val("zero_strb", last_rdata, 32'hDEADABEF);

`ifndef SRAM_LIKE_RAND_STALL_EN
      st_sum = 0;
      for (int i = 0; i < 6; i++) begin
         do_req(1'b0, 32'h10, 32'h0, 4'h0, st);
         if (i == 4) check_val("full_stall", 32'(st), 32'd1);
         else        st_sum += st;
      end
      check_val("full_other_stalls", 32'(st_sum), 32'd0);
      drain();
`endif

      do_req(1'b1, 32'h0000_0004, 32'h11223344, 4'hF, st);
      do_req(1'b0, 32'h0000_1004, 32'h0, 4'h0, st);
      drain();
      check_val("alias_rd", last_rdata, 32'h11223344);

      do_req(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, st);
      do_req(1'b0, 32'h4, 32'h0, 4'h0, st);
      do_req(1'b1, 32'h20, 32'h00000055, 4'hF, st);
      dok0 = n_dok;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check_val("rst_drop", 32'(n_dok), 32'(dok0));
      do_req(1'b0, 32'h10, 32'h0, 4'h0, st);
      drain();
      check_val("rst_mem_kept", last_rdata, 32'hCAFEF00D);

      do_req(1'b1, 32'h30, 32'hA5A5_5A5A, 4'hF, st);
      for (int i = 0; i < 24; i++) begin
         do_req(1'($urandom_range(0, 1)), atab[$urandom_range(0, 3)], $urandom, 4'($urandom_range(0, 15)), st);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      drain();

`ifdef SRAM_LIKE_RAND_STALL_EN
      st_sum = 0;
      for (int i = 0; i < 200; i++) begin
         do_req(1'b0, 32'h10, 32'h0, 4'h0, st);
         st_sum += st;
      end
      drain();
      check_val("stall_duty", 32'(st_sum >= 100 && st_sum <= 300), 32'd1);
`endif

      check_val("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
